// File: rtl/btn_conditioner.sv
// Push-button conditioner: input synchroniser, debounce FSM,
// press/release pulses and a wrapping 16-bit press counter.
module btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    output logic        btn_level,
    output logic        btn_press,
    output logic        btn_release,
    output logic [15:0] press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic [15:0]            press_count_q;
    logic [15:0]            press_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s             = sync_q[SYNC_STAGES-1];
    assign cnt_d         = cnt_q + 1'b1;
    assign press_count_d = press_count_q + 16'd1;

    // Any reversal of s while waiting drops back to the idle state,
    // so qualification always restarts from a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE_LOW;
            cnt_q         <= '0;
            level_q       <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            press_count_q <= 16'h0000;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q       <= IDLE_HIGH;
                        level_q       <= 1'b1;
                        press_q       <= 1'b1;
                        press_count_q <= press_count_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= IDLE_LOW;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_count = press_count_q;

endmodule
